fx_bus_arb: RTL and testbench
=============================

Name: fx_bus_arb

Overview:
- Two-master arbiter and sequencer for the slave FPGA's fx register bus (fx_waddr/fx_wr/fx_data, fx_raddr/fx_rd/fx_q).
- Master 0 is the 485 command path (control_top); master 1 is the local status/housekeeping poller.
- Grants the bus round-robin, issues one single-beat write or read per grant, returns read data and a one-cycle ack.
- Sits between control_top and the register file in top_s.

Parameters:
- AW, 16, fx address width.
- DW, 16, fx data width.
- RD_LAT, 1, cycles from the fx_rd cycle to fx_q valid at the slave (1..7).

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- m0_req  in  1  master 0 request; held with command until m0_ack.
- m0_we  in  1  master 0: 1=write, 0=read.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_ack  out  1  master 0 done, one-cycle pulse.
- m0_rdata  out  DW  master 0 read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1.
- fx_waddr  out  AW  write address.
- fx_wr  out  1  write strobe, one cycle.
- fx_data  out  DW  write data.
- fx_raddr  out  AW  read address.
- fx_rd  out  1  read strobe, one cycle.
- fx_q  in  DW  read data from slave.
- busy  out  1  high in any state other than IDLE.
- gnt  out  2  one-hot current owner; 00 in IDLE.

Behaviour:
- All outputs are registered.
- Reset: every output is 0; state is IDLE; rr_last=1, so m0 wins the first tie. Reset mid-transaction aborts it with no ack and drops strobes on the next edge.
- States: IDLE, WR, RD, RD_WAIT, DONE.
- IDLE: sample m0_req/m1_req.
  - If none is set, stay in IDLE.
  - If one is set, grant it.
  - If both are set, grant the master that is not rr_last.
  - On grant: latch we/addr/wdata of the winner, set gnt, update rr_last to the winner, then go to WR if we=1, else RD.
- WR: fx_wr=1 with fx_waddr/fx_data = latched values, for exactly one cycle; go to DONE.
- RD: fx_rd=1 with fx_raddr = latched address, for exactly one cycle; load wait counter = RD_LAT-1; go to RD_WAIT.
- RD_WAIT:
  - If counter=0, capture fx_q into the winner's rdata register and go to DONE.
  - Otherwise decrement the counter.
  - The capture edge is RD_LAT cycles after the fx_rd cycle.
- DONE:
  - Winner's ack=1 for one cycle; rdata is valid for reads and unchanged for writes.
  - Requests are not sampled.
  - Next state is IDLE, with gnt=00.
- Master rule: the master drops req (or presents a new command) on the edge where it sees ack. A req still high in IDLE is a new transaction.
- Latency, req first seen in IDLE at cycle 0:
  - Write: fx_wr at cycle 1, ack at cycle 2, IDLE at cycle 3.
  - Read: fx_rd at cycle 1, ack at cycle 2+RD_LAT.
- Throughput: back-to-back writes from one master run one per 3 cycles.
- Fairness: both masters requesting continuously strictly alternate; neither starves.
- Latched command: changes on mN_* after grant are ignored; the non-granted master's inputs are ignored until the next IDLE.
- Strobes: fx_wr and fx_rd are never high together, and never high outside WR/RD.
- fx_waddr/fx_raddr/fx_data hold their last values when idle; consumers qualify them with the strobes only.
- rdata registers are per-master and hold their value between acks.

Decomposition:
- Shared package fx_pkg:
  - AW/DW defaults.
  - State encoding constants for IDLE/WR/RD/RD_WAIT/DONE.
  - Master index constants M0=0, M1=1.
- One natural sub-module, rr_arb2: two-request round-robin pick with the rr_last register, combinational pick plus registered pointer update on grant.
- The FSM, command latch and rdata capture stay in fx_bus_arb.

Test Plan:
- Reset then m0 write (addr 0x0010, data 0xA5A5) -> fx_wr=1 at cycle 1 with waddr=0x0010/data=0xA5A5; m0_ack at cycle 2; gnt=01 during cycles 1-2; m1_ack never asserts.
- m1 read of 0x0020 with RD_LAT=3, slave returns 0x1234 three cycles after fx_rd -> fx_rd at cycle 1; m1_ack at cycle 5 with m1_rdata=0x1234; m0_rdata unchanged.
- m0 and m1 both raise req in the same cycle after reset and hold it across 4 transactions -> grant order m0,m1,m0,m1; each ack is one cycle; m0_ack/m1_ack never overlap.
- m0 keeps req high for 10 back-to-back writes while m1 is idle, then m1 requests -> m0 gets one ack per 3 cycles; m1 is granted at the first IDLE after its req rises.
- Assert rst during RD_WAIT (RD_LAT=4) -> next edge: all outputs 0, no ack, busy=0; the next request after reset is granted to m0 on a tie.
- m0 changes m0_addr to 0x00FF while in WR/DONE -> fx_waddr stays at the latched 0x0010; no second fx_wr.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus arbiter: default widths,
// sequencer state encoding and master index constants.
package fx_pkg;

  localparam int FX_AW = 16;
  localparam int FX_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/fx_bus_arb_if.sv
// Bundle of the two master command ports and the fx register bus.
// The master modport is the arbiter's view; slave is the environment's view.
interface fx_bus_arb_if import fx_pkg::*; #(
  parameter int AW = FX_AW,
  parameter int DW = FX_DW
) ();
  logic          m0_req, m0_we, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic [DW-1:0] fx_data, fx_q;
  logic          fx_wr, fx_rd;
  logic          busy;
  logic [1:0]    gnt;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
    input  fx_q,
    output busy, gnt
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
    output fx_q,
    input  busy, gnt
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. On a tie the master that did not win
// last time is chosen; the pointer only moves when a grant is taken.
module rr_arb2 import fx_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant,
  output logic       pick
);
  logic rr_last;

  // combinational winner: tie goes to the non-last master
  always_comb begin
    pick = M0;
    if (req == 2'b11)              pick = ~rr_last;
    else if (req[1] && !req[0])    pick = M1;
  end

  // pointer remembers the most recent winner; M1 after reset so M0 wins first tie
  always_ff @(posedge clk) begin
    if (rst)        rr_last <= M1;
    else if (grant) rr_last <= pick;
  end
endmodule

// File: rtl/fx_bus_arb.sv
// Two-master arbiter/sequencer for the fx register bus. Each grant issues
// one single-beat write or read, then a one-cycle ack to the winner.
// All outputs are registered, loaded from the next-state decision.
module fx_bus_arb import fx_pkg::*; #(
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW,
  parameter int RD_LAT = 1
) (
  input  logic         clk_sys,
  input  logic         rst,
  fx_bus_arb_if.master bus
);
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t        state, nstate;
  logic [2:0]    cnt;
  logic          win;
  logic          pick, gnt_en, pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  assign gnt_en     = (state == S_IDLE) && (bus.m0_req || bus.m1_req);
  assign pick_we    = pick ? bus.m1_we    : bus.m0_we;
  assign pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
  assign pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;

  rr_arb2 u_rr (
    .clk   (clk_sys),
    .rst   (rst),
    .req   ({bus.m1_req, bus.m0_req}),
    .grant (gnt_en),
    .pick  (pick)
  );

  // state register and read-latency counter
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (state == S_RD)                         cnt <= WAIT_INIT;
      else if (state == S_RD_WAIT && cnt != '0)  cnt <= cnt - 3'd1;
    end
  end

  // next-state decision
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:    if (gnt_en) nstate = pick_we ? S_WR : S_RD;
      S_WR:      nstate = S_DONE;
      S_RD:      nstate = S_RD_WAIT;
      S_RD_WAIT: if (cnt == '0) nstate = S_DONE;
      S_DONE:    nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  // registered outputs: strobes/ack/busy follow the state being entered;
  // the fx address/data registers double as the command latch
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      win          <= M0;
      bus.fx_wr    <= 1'b0;
      bus.fx_rd    <= 1'b0;
      bus.fx_waddr <= '0;
      bus.fx_data  <= '0;
      bus.fx_raddr <= '0;
      bus.m0_ack   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.busy     <= 1'b0;
      bus.gnt      <= 2'b00;
    end else begin
      bus.fx_wr  <= (nstate == S_WR);
      bus.fx_rd  <= (nstate == S_RD);
      bus.busy   <= (nstate != S_IDLE);
      bus.m0_ack <= (nstate == S_DONE) && (win == M0);
      bus.m1_ack <= (nstate == S_DONE) && (win == M1);
      if (gnt_en) begin
        win     <= pick;
        bus.gnt <= (pick == M1) ? 2'b10 : 2'b01;
        if (pick_we) begin
          bus.fx_waddr <= pick_addr;
          bus.fx_data  <= pick_wdata;
        end else begin
          bus.fx_raddr <= pick_addr;
        end
      end else if (nstate == S_IDLE) begin
        bus.gnt <= 2'b00;
      end
      if (state == S_RD_WAIT && cnt == '0) begin
        if (win == M1) bus.m1_rdata <= bus.fx_q;
        else           bus.m0_rdata <= bus.fx_q;
      end
    end
  end
endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb: directed stimulus, a transaction-timeline model
// compared every cycle, plus literal checks on key cycles.
module tb_fx_bus_arb;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx_bus_arb_if bus ();

  fx_bus_arb #(.AW(16), .DW(16), .RD_LAT(RD_LAT)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // slave: returns data for the fx_rd address exactly RD_LAT cycles later,
  // garbage otherwise so a mistimed capture is visible
  function automatic logic [15:0] slave_val(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  logic [RD_LAT-1:0] rv = '0;
  logic [15:0]       ra [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    rv    <= {rv[RD_LAT-2:0], bus.fx_rd === 1'b1};
    ra[0] <= bus.fx_raddr;
    for (int i = 1; i < RD_LAT; i++) ra[i] <= ra[i-1];
  end
  assign bus.fx_q = rv[RD_LAT-1] ? slave_val(ra[RD_LAT-1]) : 16'hDEAD;

  // model: a transaction is a timeline of cycles 1..endk after the grant cycle
  bit          mv = 0, act = 0, own = 0, mwe = 0, last = 1;
  int          k = 0, endk = 0;
  logic [15:0] maddr = '0, mwd = '0;
  logic [15:0] e_waddr = '0, e_data = '0, e_raddr = '0;
  logic [15:0] e_rd [2] = '{default: '0};

  always @(negedge clk) begin
    if (mv) begin
      chk("gnt",      bus.gnt,      act ? (own ? 2'b10 : 2'b01) : 2'b00);
      chk("busy",     bus.busy,     act);
      chk("fx_wr",    bus.fx_wr,    act && mwe && k == 1);
      chk("fx_rd",    bus.fx_rd,    act && !mwe && k == 1);
      chk("m0_ack",   bus.m0_ack,   act && !own && k == endk);
      chk("m1_ack",   bus.m1_ack,   act && own && k == endk);
      chk("fx_waddr", bus.fx_waddr, e_waddr);
      chk("fx_data",  bus.fx_data,  e_data);
      chk("fx_raddr", bus.fx_raddr, e_raddr);
      chk("m0_rdata", bus.m0_rdata, e_rd[0]);
      chk("m1_rdata", bus.m1_rdata, e_rd[1]);
    end
    if (rst) begin
      mv = 1; act = 0; last = 1;
      e_waddr = '0; e_data = '0; e_raddr = '0;
      e_rd[0] = '0; e_rd[1] = '0;
    end else if (mv) begin
      if (act) begin
        if (k == endk) act = 0;
        else begin
          k++;
          if (k == endk && !mwe) e_rd[own] = slave_val(maddr);
        end
      end else if (bus.m0_req || bus.m1_req) begin
        own   = (bus.m0_req && bus.m1_req) ? !last : !bus.m0_req;
        last  = own;
        mwe   = own ? bus.m1_we : bus.m0_we;
        maddr = own ? bus.m1_addr : bus.m0_addr;
        mwd   = own ? bus.m1_wdata : bus.m0_wdata;
        act   = 1; k = 1;
        endk  = mwe ? 2 : 2 + RD_LAT;
        if (mwe) begin e_waddr = maddr; e_data = mwd; end
        else     e_raddr = maddr;
      end
    end
  end

  // n = number of negedges waited, counting the ack cycle itself
  task automatic wait_ack(input bit m, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((m ? bus.m1_ack : bus.m0_ack) === 1'b1) begin n = i; break; end
    end
    if (n == 0) begin
      total++; bad++;
      $display("FAIL ack_timeout m%0d", m);
    end
  endtask

  task automatic wait_any(output bit who, output int n);
    n = 0; who = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        who = bus.m1_ack; n = i; break;
      end
    end
    if (n == 0) begin
      total++; bad++;
      $display("FAIL any_ack_timeout");
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit who;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    rst = 1;
    repeat (3) nxt();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_wr", bus.fx_wr, 0);
    nxt(); rst = 0;
    nxt();

    // m0 write, address changed mid-transaction must not leak through
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0010; bus.m0_wdata = 16'hA5A5;
    @(negedge clk);
    chk("t1_c0_wr", bus.fx_wr, 0);
    nxt(); bus.m0_addr = 16'h00FF;
    @(negedge clk);
    chk("t1_c1_wr", bus.fx_wr, 1);
    chk("t1_c1_waddr", bus.fx_waddr, 16'h0010);
    chk("t1_c1_data", bus.fx_data, 16'hA5A5);
    chk("t1_c1_gnt", bus.gnt, 2'b01);
    @(negedge clk);
    chk("t1_c2_ack", bus.m0_ack, 1);
    chk("t1_c2_gnt", bus.gnt, 2'b01);
    chk("t1_c2_waddr", bus.fx_waddr, 16'h0010);
    nxt(); bus.m0_req = 0;
    @(negedge clk);
    chk("t1_c3_busy", bus.busy, 0);
    chk("t1_c3_wr", bus.fx_wr, 0);
    nxt();

    // m1 read with RD_LAT=3: ack at cycle 5
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 16'h0020;
    wait_ack(1, n);
    chk("t2_lat", n, 6);
    chk("t2_rdata", bus.m1_rdata, 16'h1234);
    chk("t2_m0_rdata", bus.m0_rdata, 16'h0000);
    nxt(); bus.m1_req = 0;

    // both hold requests: strict alternation starting with m0
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0100; bus.m0_wdata = 16'h1111;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 16'h0200;
    for (int j = 0; j < 4; j++) begin
      wait_any(who, n);
      chk($sformatf("t3_order%0d", j), who, j % 2);
      chk("t3_overlap", bus.m0_ack & bus.m1_ack, 0);
      nxt();
      if (j == 3) begin bus.m0_req = 0; bus.m1_req = 0; end
    end

    // m0 back-to-back writes, one per 3 cycles; then m1 joins and wins the tie
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0300; bus.m0_wdata = 16'h0000;
    for (int j = 0; j < 10; j++) begin
      wait_ack(0, n);
      chk($sformatf("t4_gap%0d", j), n, 3);
      nxt();
      bus.m0_addr = 16'h0301 + 16'(j); bus.m0_wdata = 16'(j + 1);
    end
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 16'h0500; bus.m1_wdata = 16'h5555;
    wait_any(who, n);
    chk("t4_m1_first", who, 1);
    chk("t4_m1_lat", n, 3);
    nxt(); bus.m1_req = 0;
    wait_ack(0, n);
    chk("t4_m0_after", n, 3);
    nxt(); bus.m0_req = 0;

    // reset during RD_WAIT aborts with no ack; next tie goes to m0
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0040;
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", bus.busy, 1);
    nxt(); rst = 1; bus.m0_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy", bus.busy, 0);
    chk("t5_gnt", bus.gnt, 0);
    chk("t5_ack", bus.m0_ack, 0);
    chk("t5_m1_rdata", bus.m1_rdata, 0);
    nxt(); rst = 0;
    repeat (3) nxt();
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0600; bus.m0_wdata = 16'h6666;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 16'h0700; bus.m1_wdata = 16'h7777;
    wait_any(who, n);
    chk("t5_tie_m0", who, 0);
    chk("t5_tie_lat", n, 3);
    nxt(); bus.m0_req = 0;
    wait_ack(1, n);
    chk("t5_m1_lat", n, 3);
    nxt(); bus.m1_req = 0;
    repeat (4) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
